// File: rtl/maxnet_weight_buffer_if.sv
// Bundle of the refill, write and row-read signals between the MaxNet
// controller (master) and the weight buffer (slave).
interface maxnet_weight_buffer_if #(
  parameter int N     = 4,
  parameter int WIDTH = 32
);
  localparam int AW = $clog2(N);

  logic               init_start;
  logic [WIDTH-1:0]   init_neg_eps;
  logic               busy;
  logic               init_done;
  logic               wr_en;
  logic [AW-1:0]      wr_row;
  logic [AW-1:0]      wr_col;
  logic [WIDTH-1:0]   wr_data;
  logic               rd_en;
  logic [AW-1:0]      rd_row;
  logic [N*WIDTH-1:0] rd_data;
  logic               rd_valid;
  logic               addr_err;

  modport master (
    output init_start, init_neg_eps, wr_en, wr_row, wr_col, wr_data, rd_en, rd_row,
    input  busy, init_done, rd_data, rd_valid, addr_err
  );

  modport slave (
    input  init_start, init_neg_eps, wr_en, wr_row, wr_col, wr_data, rd_en, rd_row,
    output busy, init_done, rd_data, rd_valid, addr_err
  );
endinterface

// File: rtl/maxnet_weight_buffer.sv
// MaxNet lateral-inhibition weight matrix: N x N IEEE-754 words, 1.0 on the
// diagonal and -eps elsewhere, with a refill sequencer, a single-word write
// port and a registered row-read port.
//
//   state | meaning
//   IDLE  | accepting reads, writes and init_start
//   FILL  | rewriting one element per cycle, idx 0 .. N*N-1
//   DONE  | one-cycle init_done pulse, back to IDLE
module maxnet_weight_buffer #(
  parameter int               N           = 4,
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] DEF_NEG_EPS = 32'hBE4CCCCD,
  parameter logic [WIDTH-1:0] ONE         = 32'h3F800000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  maxnet_weight_buffer_if.slave bus
);
  localparam int              AW       = $clog2(N);
  localparam int              IW       = $clog2(N*N);
  localparam logic [AW:0]     NLIM     = (AW+1)'(N);
  localparam logic [IW-1:0]   LAST     = IW'(N*N-1);
  localparam logic [AW-1:0]   COL_LAST = AW'(N-1);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t             state, state_nxt;
  logic [IW-1:0]      idx;
  logic [AW-1:0]      fill_row, fill_col;
  logic [WIDTH-1:0]   eps_reg;
  logic               fill_we, load_eps;
  logic               idle, wr_ok, rd_ok, req_err;
  logic [N*WIDTH-1:0] rows [N];
  logic [N*WIDTH-1:0] rd_mux;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next-state decode and sequencer outputs
  always_comb begin
    state_nxt     = state;
    fill_we       = 1'b0;
    load_eps      = 1'b0;
    bus.busy      = 1'b0;
    bus.init_done = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.init_start) begin
          load_eps  = 1'b1;
          state_nxt = FILL;
        end
      end
      FILL: begin
        bus.busy = 1'b1;
        fill_we  = 1'b1;
        if (idx == LAST) state_nxt = DONE;
      end
      DONE: begin
        bus.init_done = 1'b1;
        state_nxt     = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // refill index, row/column tracking and latched eps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= '0;
      fill_row <= '0;
      fill_col <= '0;
      eps_reg  <= DEF_NEG_EPS;
    end else if (load_eps) begin
      idx      <= '0;
      fill_row <= '0;
      fill_col <= '0;
      eps_reg  <= bus.init_neg_eps;
    end else if (fill_we && idx != LAST) begin
      idx <= idx + IW'(1);
      if (fill_col == COL_LAST) begin
        fill_col <= '0;
        fill_row <= fill_row + AW'(1);
      end else begin
        fill_col <= fill_col + AW'(1);
      end
    end
  end

  assign idle    = (state == IDLE);
  assign wr_ok   = bus.wr_en && idle && ({1'b0, bus.wr_row} < NLIM) && ({1'b0, bus.wr_col} < NLIM);
  assign rd_ok   = bus.rd_en && idle && ({1'b0, bus.rd_row} < NLIM);
  // A rejected write and a rejected read in one cycle share a single pulse.
  assign req_err = (bus.wr_en && !wr_ok) || (bus.rd_en && !rd_ok);

  for (genvar r = 0; r < N; r++) begin : g_row
    for (genvar c = 0; c < N; c++) begin : g_col
      localparam logic [WIDTH-1:0] RST_VAL = (r == c) ? ONE : DEF_NEG_EPS;
      logic [WIDTH-1:0] q;
      logic             fill_hit, wr_hit;

      assign fill_hit = fill_we && (fill_row == AW'(r)) && (fill_col == AW'(c));
      assign wr_hit   = wr_ok && (bus.wr_row == AW'(r)) && (bus.wr_col == AW'(c));

      // element (r,c): refill has priority, though writes only land in IDLE anyway
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        q <= RST_VAL;
        else if (fill_hit) q <= (r == c) ? ONE : eps_reg;
        else if (wr_hit)   q <= bus.wr_data;
      end

      assign rows[r][c*WIDTH +: WIDTH] = q;
    end
  end

  assign rd_mux = rows[bus.rd_row];

  // registered read port; rd_data samples the pre-write row (read-before-write)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rd_data  <= '0;
      bus.rd_valid <= 1'b0;
      bus.addr_err <= 1'b0;
    end else begin
      bus.rd_valid <= rd_ok;
      bus.addr_err <= req_err;
      if (rd_ok) bus.rd_data <= rd_mux;
    end
  end
endmodule

// File: tb/tb_maxnet_weight_buffer.sv
// Bench for maxnet_weight_buffer: an N=4 instance checked through a row
// scoreboard, and an N=5 instance for out-of-range addressing.
module tb_maxnet_weight_buffer;
  localparam logic [31:0] ONE = 32'h3F800000;
  localparam logic [31:0] DEF = 32'hBE4CCCCD;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  maxnet_weight_buffer_if #(.N(4), .WIDTH(32)) bus4();
  maxnet_weight_buffer_if #(.N(5), .WIDTH(32)) bus5();

  maxnet_weight_buffer #(.N(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));
  maxnet_weight_buffer #(.N(5)) u5 (.clk(clk), .rst_n(rst_n), .bus(bus5.slave));

  int errors = 0;
  int checks = 0;

  logic [31:0]  m4 [4][4];
  logic [127:0] sbq [$];
  logic [127:0] mon_exp;

  function automatic logic [127:0] row4(input int r);
    logic [127:0] v;
    for (int c = 0; c < 4; c++) v[c*32 +: 32] = m4[r][c];
    return v;
  endfunction

  function automatic logic [159:0] row5_reset(input int r);
    logic [159:0] v;
    for (int c = 0; c < 5; c++) v[c*32 +: 32] = (r == c) ? ONE : DEF;
    return v;
  endfunction

  task automatic model_fill4(input logic [31:0] e);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        m4[r][c] = (r == c) ? ONE : e;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus4.init_start = 0; bus4.init_neg_eps = '0; bus4.wr_en = 0; bus4.wr_row = '0;
    bus4.wr_col = '0; bus4.wr_data = '0; bus4.rd_en = 0; bus4.rd_row = '0;
    bus5.init_start = 0; bus5.init_neg_eps = '0; bus5.wr_en = 0; bus5.wr_row = '0;
    bus5.wr_col = '0; bus5.wr_data = '0; bus5.rd_en = 0; bus5.rd_row = '0;
  endtask

  // issue back-to-back reads of all four rows, expectations from the model
  task automatic read_all4();
    for (int r = 0; r < 4; r++) begin
      bus4.rd_en = 1; bus4.rd_row = 2'(r);
      sbq.push_back(row4(r));
      tick();
    end
    bus4.rd_en = 0;
    tick();
  endtask

  // scoreboard consumer: every rd_valid pops one expected row
  always @(negedge clk) begin
    if (bus4.rd_valid === 1'b1) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL rd_valid_unexpected: rd_valid=1 rd_data=%h, no read outstanding", bus4.rd_data);
      end else begin
        mon_exp = sbq.pop_front();
        if (bus4.rd_data !== mon_exp) begin
          errors++;
          $display("FAIL rd_row_data: got %h expected %h", bus4.rd_data, mon_exp);
        end
      end
    end
  end

  task automatic test_reset();
    rst_n = 0;
    idle_inputs();
    tick(); tick();
    checks++;
    if ({bus4.busy, bus4.init_done, bus4.rd_valid, bus4.addr_err} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: busy/done/valid/err=%b expected 0000",
               {bus4.busy, bus4.init_done, bus4.rd_valid, bus4.addr_err});
    end
    checks++;
    if (bus4.rd_data !== 128'h0) begin
      errors++;
      $display("FAIL reset_rd_data: got %h expected 0", bus4.rd_data);
    end
    model_fill4(DEF);
    rst_n = 1;
    tick();
    read_all4();
    checks++;
    if (bus4.rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid_len: rd_valid=%b expected 0 after last read", bus4.rd_valid);
    end
    // single read: valid for exactly one cycle
    bus4.rd_en = 1; bus4.rd_row = 2'd1; sbq.push_back(row4(1));
    tick();
    bus4.rd_en = 0;
    checks++;
    if (bus4.rd_valid !== 1'b1) begin
      errors++;
      $display("FAIL single_read_valid: rd_valid=%b expected 1", bus4.rd_valid);
    end
    tick();
    checks++;
    if (bus4.rd_valid !== 1'b0 || bus4.busy !== 1'b0 || bus4.init_done !== 1'b0) begin
      errors++;
      $display("FAIL single_read_pulse: valid/busy/done=%b expected 000",
               {bus4.rd_valid, bus4.busy, bus4.init_done});
    end
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL reset_drain: %0d reads outstanding expected 0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic test_read_before_write();
    bus4.wr_en = 1; bus4.wr_row = 2'd0; bus4.wr_col = 2'd3; bus4.wr_data = 32'h40000000;
    bus4.rd_en = 1; bus4.rd_row = 2'd0;
    sbq.push_back(row4(0));
    m4[0][3] = 32'h40000000;
    tick();
    bus4.wr_en = 0;
    checks++;
    if (bus4.addr_err !== 1'b0) begin
      errors++;
      $display("FAIL rbw_addr_err: got %b expected 0", bus4.addr_err);
    end
    sbq.push_back(row4(0));
    tick();
    bus4.rd_en = 0;
    tick();
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL rbw_drain: %0d reads outstanding expected 0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic test_refill();
    int busy_cnt, done_at, pulses;
    logic busy_with_done;
    busy_cnt = 0; done_at = -1; pulses = 0; busy_with_done = 0;
    bus4.init_start = 1; bus4.init_neg_eps = 32'hBDCCCCCD;
    tick();
    bus4.init_start = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (bus4.busy === 1'b1) busy_cnt++;
      if (bus4.init_done === 1'b1) begin
        pulses++;
        if (done_at < 0) done_at = cyc;
        if (bus4.busy !== 1'b0) busy_with_done = 1;
      end
      tick();
    end
    checks++;
    if (busy_cnt != 16) begin
      errors++;
      $display("FAIL refill_busy_cycles: got %0d expected 16", busy_cnt);
    end
    checks++;
    if (done_at != 16 || pulses != 1) begin
      errors++;
      $display("FAIL refill_done_pulse: at cycle %0d count %0d expected cycle 16 count 1", done_at, pulses);
    end
    checks++;
    if (busy_with_done) begin
      errors++;
      $display("FAIL refill_busy_with_done: busy=1 during init_done expected 0");
    end
    model_fill4(32'hBDCCCCCD);
    bus4.rd_en = 1; bus4.rd_row = 2'd2; sbq.push_back(row4(2));
    tick();
    bus4.rd_en = 0;
    read_all4();
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL refill_drain: %0d reads outstanding expected 0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic test_busy_reject();
    int waited;
    // write accepted at the same edge as init_start, then overwritten by refill
    bus4.init_start = 1; bus4.init_neg_eps = 32'hBE000000;
    bus4.wr_en = 1; bus4.wr_row = 2'd2; bus4.wr_col = 2'd1; bus4.wr_data = 32'hAAAA5555;
    tick();
    bus4.init_start = 0; bus4.wr_en = 0;
    checks++;
    if (bus4.addr_err !== 1'b0 || bus4.busy !== 1'b1) begin
      errors++;
      $display("FAIL start_with_write: addr_err/busy=%b expected 01", {bus4.addr_err, bus4.busy});
    end
    tick(); tick();
    bus4.wr_en = 1; bus4.wr_row = 2'd1; bus4.wr_col = 2'd0; bus4.wr_data = 32'h12345678;
    bus4.rd_en = 1; bus4.rd_row = 2'd0;
    bus4.init_start = 1; bus4.init_neg_eps = 32'h3F000000;
    tick();
    bus4.wr_en = 0; bus4.rd_en = 0; bus4.init_start = 0;
    checks++;
    if (bus4.addr_err !== 1'b1 || bus4.rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL busy_reject: addr_err/rd_valid=%b expected 10", {bus4.addr_err, bus4.rd_valid});
    end
    tick();
    checks++;
    if (bus4.addr_err !== 1'b0) begin
      errors++;
      $display("FAIL busy_reject_pulse: addr_err=%b expected 0", bus4.addr_err);
    end
    waited = 0;
    while (bus4.init_done !== 1'b1 && waited < 40) begin
      tick();
      waited++;
    end
    checks++;
    if (bus4.init_done !== 1'b1) begin
      errors++;
      $display("FAIL busy_reject_timeout: init_done=%b expected 1 within 40 cycles", bus4.init_done);
    end
    tick();
    model_fill4(32'hBE000000);
    read_all4();
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL busy_reject_drain: %0d reads outstanding expected 0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic test_reset_mid_refill();
    int bad;
    bus4.init_start = 1; bus4.init_neg_eps = 32'hBD000000;
    tick();
    bus4.init_start = 0;
    repeat (8) tick();
    rst_n = 0;
    #1;
    checks++;
    if ({bus4.busy, bus4.init_done, bus4.rd_valid} !== 3'b000 || bus4.rd_data !== 128'h0) begin
      errors++;
      $display("FAIL mid_reset_state: busy/done/valid=%b rd_data=%h expected 000 and 0",
               {bus4.busy, bus4.init_done, bus4.rd_valid}, bus4.rd_data);
    end
    tick(); tick();
    rst_n = 1;
    bad = 0;
    for (int i = 0; i < 24; i++) begin
      if (bus4.init_done !== 1'b0 || bus4.busy !== 1'b0) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL mid_reset_no_done: %0d cycles with busy/init_done set expected 0", bad);
    end
    model_fill4(DEF);
    read_all4();
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL mid_reset_drain: %0d reads outstanding expected 0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic test_out_of_range();
    logic [159:0] exp5;
    bus5.rd_en = 1; bus5.rd_row = 3'd4;
    tick();
    bus5.rd_en = 0;
    checks++;
    if (bus5.rd_valid !== 1'b1 || bus5.rd_data !== row5_reset(4)) begin
      errors++;
      $display("FAIL n5_read_row4: valid=%b data=%h expected 1 %h", bus5.rd_valid, bus5.rd_data, row5_reset(4));
    end
    bus5.rd_en = 1; bus5.rd_row = 3'd7;
    tick();
    bus5.rd_en = 0;
    checks++;
    if (bus5.addr_err !== 1'b1 || bus5.rd_valid !== 1'b0 || bus5.rd_data !== row5_reset(4)) begin
      errors++;
      $display("FAIL n5_read_oor: err=%b valid=%b data=%h expected 1 0 %h",
               bus5.addr_err, bus5.rd_valid, bus5.rd_data, row5_reset(4));
    end
    tick();
    checks++;
    if (bus5.addr_err !== 1'b0) begin
      errors++;
      $display("FAIL n5_read_oor_pulse: addr_err=%b expected 0", bus5.addr_err);
    end
    bus5.wr_en = 1; bus5.wr_row = 3'd0; bus5.wr_col = 3'd6; bus5.wr_data = 32'hDEADBEEF;
    tick();
    bus5.wr_en = 0;
    checks++;
    if (bus5.addr_err !== 1'b1) begin
      errors++;
      $display("FAIL n5_write_oor: addr_err=%b expected 1", bus5.addr_err);
    end
    // rejected write and rejected read together: one pulse
    bus5.wr_en = 1; bus5.wr_row = 3'd5; bus5.wr_col = 3'd0; bus5.wr_data = 32'h0BADF00D;
    bus5.rd_en = 1; bus5.rd_row = 3'd7;
    tick();
    bus5.wr_en = 0; bus5.rd_en = 0;
    checks++;
    if (bus5.addr_err !== 1'b1 || bus5.rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL n5_dual_reject: err/valid=%b expected 10", {bus5.addr_err, bus5.rd_valid});
    end
    tick();
    checks++;
    if (bus5.addr_err !== 1'b0) begin
      errors++;
      $display("FAIL n5_dual_reject_pulse: addr_err=%b expected 0", bus5.addr_err);
    end
    bus5.wr_en = 1; bus5.wr_row = 3'd4; bus5.wr_col = 3'd4; bus5.wr_data = 32'hCAFEF00D;
    tick();
    bus5.wr_en = 0;
    for (int r = 0; r < 5; r++) begin
      exp5 = row5_reset(r);
      if (r == 4) exp5[4*32 +: 32] = 32'hCAFEF00D;
      bus5.rd_en = 1; bus5.rd_row = 3'(r);
      tick();
      checks++;
      if (bus5.rd_valid !== 1'b1 || bus5.rd_data !== exp5) begin
        errors++;
        $display("FAIL n5_row%0d: valid=%b data=%h expected 1 %h", r, bus5.rd_valid, bus5.rd_data, exp5);
      end
    end
    bus5.rd_en = 0;
    tick();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_read_before_write();
    test_refill();
    test_busy_reject();
    test_reset_mid_refill();
    test_out_of_range();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/maxnet_weight_buffer.md
# maxnet_weight_buffer

Parametrised register bank holding the N×N MaxNet lateral-inhibition weight matrix in IEEE-754 single precision: 1.0 on the diagonal, −ε elsewhere. It replaces the fixed 4×4 constant buffer and adds:
- a programmable-ε refill sequencer,
- a single-word write port,
- a registered row-read port.

It sits between the MaxNet controller and the multiply-accumulate datapath, which consumes one weight row per iteration step.

## Interface
Parameters:
- N, 4, neuron count (2..16); matrix is N×N words.
- WIDTH, 32, word width (IEEE-754 single).
- DEF_NEG_EPS, 32'hBE4CCCCD, off-diagonal reset value (−0.2).
- ONE, 32'h3F800000, diagonal value (1.0).
- AW, $clog2(N), row/column index width (derived, not overridden).

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- init_start  in  1  pulse: refill whole matrix using init_neg_eps.
- init_neg_eps  in  WIDTH  off-diagonal value for refill, sampled with init_start.
- busy  out  1  high while refill in progress.
- init_done  out  1  one-cycle pulse after refill completes.
- wr_en  in  1  single-word write strobe.
- wr_row, wr_col  in  AW  write address.
- wr_data  in  WIDTH  write data.
- rd_en  in  1  row read request.
- rd_row  in  AW  row to read.
- rd_data  out  N*WIDTH  row contents; column c at bits [c*WIDTH +: WIDTH].
- rd_valid  out  1  rd_data valid, one cycle per accepted request.
- addr_err  out  1  one-cycle pulse: out-of-range or busy-rejected access.

## Operation
- Storage: N*N registers; element (r,c) at linear index r*N+c.
- Async reset (rst_n low) forces:
  - element (r,r) = ONE; all other elements = DEF_NEG_EPS.
  - FSM = IDLE.
  - busy, init_done, rd_valid, addr_err = 0; rd_data = 0; eps_reg = DEF_NEG_EPS.
- Reset mid-refill aborts the refill; the matrix reverts to the reset pattern.
- FSM states IDLE, FILL, DONE:
  - IDLE: init_start=1 → latch eps_reg=init_neg_eps, idx=0, go FILL.
  - FILL: write element idx (ONE if row==col, else eps_reg); idx+1. After idx=N*N−1 is written → DONE.
  - DONE: init_done=1 for this cycle → IDLE.
- init_start outside IDLE is ignored with no error.
- idx counter width is $clog2(N*N); it counts through N*N−1 and does not wrap in FILL.
- Write port:
  - Accepted only in IDLE with wr_row<N and wr_col<N; element updated at the clock edge.
  - wr_en in FILL/DONE or with an out-of-range address: no write; addr_err pulses next cycle.
- Read port:
  - Accepted only in IDLE with rd_row<N. rd_data is registered with the row contents; rd_valid=1 next cycle.
  - Rejected read: rd_valid=0, rd_data holds its previous value, addr_err pulses.
  - rd_data holds its value until the next accepted read.
- Same-cycle write and read of the same row returns the OLD value (read-before-write). The new value is visible to a read issued the following cycle.
- Same-cycle init_start and wr_en in IDLE: the write is performed at that edge, then refill overwrites it.
- No arithmetic on data. Words are stored bit-exact; no sign forcing or NaN checking.

## Timing
- Read latency: 1 cycle (request at edge k, data and rd_valid after edge k+1). Back-to-back reads every cycle are supported.
- Write latency: the element is updated at the sampling edge and is readable by a request on the next cycle.
- Refill timing (init_start sampled at edge 0):
  - busy=1 after edge 0 through edge N*N, exactly N*N cycles.
  - init_done=1 during the cycle after edge N*N; busy=0 in that cycle.
  - A new init_start is accepted at edge N*N+2 at the earliest.
- addr_err is registered: a single-cycle pulse in the cycle after the offending request. A write and a read both rejected in the same cycle produce one pulse.

## Test plan
- Reset check (N=4): release rst_n, read rows 0..3 → row 0 = {3F800000, BE4CCCCD, BE4CCCCD, BE4CCCCD}, rotating diagonal for rows 1..3; rd_valid exactly 1 cycle each; busy=0, init_done=0.
- Refill (N=4): init_start with init_neg_eps=BDCCCCCD (−0.1) → busy high for exactly 16 cycles, init_done pulse in cycle 17. Row 2 then reads {BDCCCCCD, BDCCCCCD, 3F800000, BDCCCCCD}.
- Busy rejection: during FILL issue wr_en (row1, col0, 12345678) and rd_en row 0 → no rd_valid, one addr_err pulse; after refill (1,0) = eps_reg, not 12345678.
- Read-before-write: same cycle wr_en (0,3,40000000) and rd_en row 0 → rd_data col3 = BE4CCCCD; next-cycle read of row 0 → col3 = 40000000.
- Out-of-range with N=5: rd_row=7 → addr_err=1, rd_valid=0, rd_data unchanged; wr_col=6 → no element changes.
- Reset mid-refill: drop rst_n at FILL cycle 8 → busy=0, no init_done pulse; the matrix reads back the reset pattern with DEF_NEG_EPS off-diagonal.
